// File: rtl/or8_way.sv
// or8_way: 8-input OR with a registered status bank (delayed OR, edges, popcount, low/high index, sticky).
// OUT is combinational; everything else is 1 cycle. No backpressure. STICKY is built only with OR8WAY_STICKY_EN.
module or8_way (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] X,
  input  logic       CLR,
  output logic       OUT,
  output logic       OUT_Q,
  output logic       RISE,
  output logic       FALL,
  output logic [3:0] NSET,
  output logic [2:0] LOW_IDX,
  output logic [2:0] HIGH_IDX,
  output logic       STICKY
);

  logic [3:0] cnt_c;
  logic [2:0] low_c;
  logic [2:0] high_c;

  assign OUT = |X;

  // Scan directions make the last hit win: downward for lowest, upward for highest.
  always_comb begin
    cnt_c  = 4'd0;
    low_c  = 3'd0;
    high_c = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_c = cnt_c + 4'(X[i]);
      if (X[i]) high_c = 3'(i);
    end
    for (int i = 7; i >= 0; i--) begin
      if (X[i]) low_c = 3'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_Q    <= 1'b0;
      RISE     <= 1'b0;
      FALL     <= 1'b0;
      NSET     <= 4'd0;
      LOW_IDX  <= 3'd0;
      HIGH_IDX <= 3'd0;
    end else begin
      OUT_Q    <= OUT;
      RISE     <= OUT & ~OUT_Q;
      FALL     <= ~OUT & OUT_Q;
      NSET     <= cnt_c;
      LOW_IDX  <= low_c;
      HIGH_IDX <= high_c;
    end
  end

`ifdef OR8WAY_STICKY_EN
  // Clearing loads OUT rather than 0 so an event on the clear edge is kept.
  always_ff @(posedge CLK) begin
    if (RST)      STICKY <= 1'b0;
    else if (CLR) STICKY <= OUT;
    else          STICKY <= STICKY | OUT;
  end
`else
  logic unused_clr;
  assign unused_clr = CLR;
  assign STICKY     = 1'b0;
`endif

endmodule

// File: tb/tb_or8_way.sv
// Directed self-checking bench for or8_way; STICKY expectations follow OR8WAY_STICKY_EN.
module tb_or8_way;

`ifdef OR8WAY_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  bit         clk_en = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] X = 8'h00;
  logic       CLR = 1'b0;
  logic       OUT, OUT_Q, RISE, FALL, STICKY;
  logic [3:0] NSET;
  logic [2:0] LOW_IDX, HIGH_IDX;
  logic [13:0] st;

  int checks = 0;
  int errors = 0;

  or8_way dut (
    .CLK(CLK), .RST(RST), .X(X), .CLR(CLR),
    .OUT(OUT), .OUT_Q(OUT_Q), .RISE(RISE), .FALL(FALL),
    .NSET(NSET), .LOW_IDX(LOW_IDX), .HIGH_IDX(HIGH_IDX), .STICKY(STICKY)
  );

  always #5 if (clk_en) CLK = ~CLK;

  assign st = {OUT_Q, RISE, FALL, NSET, LOW_IDX, HIGH_IDX, STICKY};

  function automatic logic [13:0] mk(input bit q, input bit r, input bit f,
                                     input int n, input int lo, input int hi, input bit s);
    return {q, r, f, 4'(n), 3'(lo), 3'(hi), s & STK_EN};
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_comb_sweep();
    for (int i = 0; i < 256; i++) begin
      X = 8'(i);
      #4;
      checks++;
      if (OUT !== (i != 0)) begin
        errors++;
        $display("FAIL comb_sweep X=%h OUT got %b exp %b", X, OUT, (i != 0));
      end
      #1;
    end
  endtask

  task automatic test_reset();
    X = 8'hFF; RST = 1'b1; CLR = 1'b0;
    clk_en = 1'b1;
    cyc(); cyc();
    checks++;
    if (OUT !== 1'b1) begin
      errors++; $display("FAIL reset_out got %b exp 1", OUT);
    end
    checks++;
    if (st !== mk(0, 0, 0, 0, 0, 0, 0)) begin
      errors++; $display("FAIL reset_state got %h exp %h", st, mk(0, 0, 0, 0, 0, 0, 0));
    end
    X = 8'h00; RST = 1'b0;
  endtask

  task automatic test_edges();
    logic [13:0] e;
    X = 8'h00;
    for (int c = 0; c < 3; c++) begin
      cyc(); checks++;
      if (st !== mk(0, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL edges_zero c=%0d got %h exp %h", c, st, mk(0, 0, 0, 0, 0, 0, 0));
      end
    end
    X = 8'h10;
    #1; checks++;
    if ({OUT, OUT_Q} !== 2'b10) begin
      errors++; $display("FAIL edges_lag_up got %b exp 10", {OUT, OUT_Q});
    end
    for (int c = 0; c < 3; c++) begin
      cyc(); checks++;
      e = mk(1, c == 0, 0, 1, 4, 4, 1);
      if (st !== e) begin
        errors++; $display("FAIL edges_rise c=%0d got %h exp %h", c, st, e);
      end
    end
    X = 8'h00;
    #1; checks++;
    if ({OUT, OUT_Q} !== 2'b01) begin
      errors++; $display("FAIL edges_lag_down got %b exp 01", {OUT, OUT_Q});
    end
    for (int c = 0; c < 3; c++) begin
      cyc(); checks++;
      e = mk(0, 0, c == 0, 0, 0, 0, 1);
      if (st !== e) begin
        errors++; $display("FAIL edges_fall c=%0d got %h exp %h", c, st, e);
      end
    end
  endtask

  task automatic test_index_count();
    logic [7:0] xv [5]  = '{8'h28, 8'h80, 8'hFF, 8'h01, 8'h5A};
    int         nv [5]  = '{2, 1, 8, 1, 4};
    int         lv [5]  = '{3, 7, 0, 0, 1};
    int         hv [5]  = '{5, 7, 7, 0, 6};
    logic [13:0] e;
    for (int k = 0; k < 5; k++) begin
      X = xv[k];
      cyc(); checks++;
      e = mk(1, 0, 0, nv[k], lv[k], hv[k], 1);
      if (st[13:11] !== 3'b100 && k > 0 || st[10:1] !== e[10:1]) begin
        errors++; $display("FAIL index_count X=%h got %h exp %h", xv[k], st, e);
      end
    end
    for (int i = 0; i < 8; i++) begin
      X = 8'h01 << i;
      cyc(); checks++;
      if ({NSET, LOW_IDX, HIGH_IDX} !== {4'd1, 3'(i), 3'(i)}) begin
        errors++; $display("FAIL single_bit i=%0d got n=%0d lo=%0d hi=%0d", i, NSET, LOW_IDX, HIGH_IDX);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xv [6] = '{8'h00, 8'h01, 8'h00, 8'h40, 8'h00, 8'h00};
    bit         rv [6] = '{0, 1, 0, 1, 0, 0};
    bit         fv [6] = '{1, 0, 1, 0, 1, 0};
    for (int k = 0; k < 6; k++) begin
      X = xv[k];
      cyc(); checks++;
      if ({RISE, FALL, OUT_Q} !== {rv[k], fv[k], xv[k] != 0}) begin
        errors++;
        $display("FAIL back_to_back k=%0d got rfq=%b exp %b", k, {RISE, FALL, OUT_Q}, {rv[k], fv[k], xv[k] != 0});
      end
    end
  endtask

  task automatic test_mid_reset();
    X = 8'hFF; cyc();
    RST = 1'b1; cyc();
    checks++;
    if (st !== mk(0, 0, 0, 0, 0, 0, 0) || OUT !== 1'b1) begin
      errors++; $display("FAIL mid_reset got %h out %b exp %h out 1", st, OUT, mk(0, 0, 0, 0, 0, 0, 0));
    end
    RST = 1'b0; cyc();
    checks++;
    if (st !== mk(1, 1, 0, 8, 0, 7, 1)) begin
      errors++; $display("FAIL post_reset_rise got %h exp %h", st, mk(1, 1, 0, 8, 0, 7, 1));
    end
  endtask

  task automatic test_sticky();
    X = 8'h00; RST = 1'b1; cyc(); RST = 1'b0;
    cyc(); checks++;
    if (STICKY !== 1'b0) begin
      errors++; $display("FAIL sticky_init got %b exp 0", STICKY);
    end
    X = 8'h01; cyc();
    X = 8'h00;
    for (int c = 0; c < 3; c++) begin
      cyc(); checks++;
      if (STICKY !== STK_EN) begin
        errors++; $display("FAIL sticky_hold c=%0d got %b exp %b", c, STICKY, STK_EN);
      end
    end
    CLR = 1'b1; cyc(); CLR = 1'b0;
    checks++;
    if (STICKY !== 1'b0) begin
      errors++; $display("FAIL sticky_clr got %b exp 0", STICKY);
    end
    X = 8'h04; cyc();
    CLR = 1'b1; cyc(); CLR = 1'b0;
    checks++;
    if (STICKY !== STK_EN || st[13:11] !== 3'b100) begin
      errors++; $display("FAIL sticky_clr_event got s=%b qrf=%b exp s=%b qrf=100", STICKY, st[13:11], STK_EN);
    end
    X = 8'h00; RST = 1'b1; CLR = 1'b1; cyc(); RST = 1'b0; CLR = 1'b0;
    checks++;
    if (STICKY !== 1'b0) begin
      errors++; $display("FAIL sticky_rst_prio got %b exp 0", STICKY);
    end
  endtask

  initial begin
    test_comb_sweep();
    test_reset();
    test_edges();
    test_index_count();
    test_back_to_back();
    test_mid_reset();
    test_sticky();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
